coin_sprite_addr_gen: RTL
=========================

Name: coin_sprite_addr_gen

Overview:
Upstream stage for the coin sprite renderer. Takes the VGA scan position plus the coin's screen position and produces a registered sprite-ROM address and a per-pixel hit flag. It also owns the coin's spin-animation frame counter and latches the coin position once per video frame, so the sprite never tears mid-scan. Outputs feed the coin ROM address port and the colour mux that chooses between the coin palette and the background.

Parameters:
SPR_W, 16, sprite width in pixels (power of 2)
SPR_H, 16, sprite height in pixels
NUM_FRAMES, 4, animation frames stored consecutively in ROM
FRAME_TICKS, 8, video frames per animation frame
ADDR_W, 13, ROM address width; NUM_FRAMES*SPR_W*SPR_H must be <= 2**ADDR_W

Ports:
vga_clk  in  1  pixel clock; all logic is on its rising edge
reset_n  in  1  synchronous, active-low reset
DrawX  in  10  current scan column
DrawY  in  10  current scan row
blank  in  1  1 = visible pixel (active video)
frame_start  in  1  one-cycle pulse at start of vertical blanking
coin_x  in  10  sprite top-left column, sampled only at frame_start
coin_y  in  10  sprite top-left row, sampled only at frame_start
coin_active  in  1  coin visible, sampled only at frame_start
anim_en  in  1  1 = animation advances
rom_address  out  ADDR_W  sprite ROM address, registered
sprite_hit  out  1  current registered pixel lies inside the sprite, registered
anim_frame  out  clog2(NUM_FRAMES)  current animation frame index

Behaviour:
- Reset (reset_n=0 at a rising edge): rom_address=0, sprite_hit=0, anim_frame=0, tick counter=0, latched x/y=0, latched active=0. Reset has priority over frame_start.
- Shadow latch: on a frame_start cycle, lx<=coin_x, ly<=coin_y, lact<=coin_active. Changes to these inputs between pulses have no effect until the next pulse.
- Animation: on frame_start with anim_en=1, tick increments.
  - When tick==FRAME_TICKS-1, tick wraps to 0 and anim_frame<=(anim_frame+1) mod NUM_FRAMES.
  - With anim_en=0, tick and anim_frame hold.
  - anim_frame advances on the same edge as the shadow latch. The new frame index applies from the first visible pixel of the next frame.
- Hit test, combinational then registered:
  - Compute dx=DrawX-lx and dy=DrawY-ly in 11-bit signed arithmetic.
  - inside = lact & blank & (0<=dx<SPR_W) & (0<=dy<SPR_H).
  - No wrap-around: with lx=630, columns 630..639 hit and column 0 never hits. The same rule applies vertically.
- Address:
  - When inside, next rom_address = anim_frame*SPR_W*SPR_H + dy*SPR_W + dx.
  - Otherwise next rom_address = 0.
  - Use shifts only; no multipliers are inferred when SPR_W and SPR_H are powers of 2.
- Latency: exactly 1 vga_clk from DrawX/DrawY/blank to rom_address and sprite_hit. The ROM reads on the falling edge, so q is valid for the consumer's next rising edge. The consumer delays its blank by 1 cycle to align.
- sprite_hit is 0 whenever blank was 0 in the previous cycle.
- frame_start coinciding with a visible pixel is legal. The pixel uses the pre-update latched values.

Decomposition:
- Package coin_sprite_pkg holds:
  - SPR_W, SPR_H, NUM_FRAMES, FRAME_TICKS defaults
  - derived FRAME_SIZE = SPR_W*SPR_H
  - screen constants H_ACTIVE=640, V_ACTIVE=480
  - typedef screen_coord_t (logic [9:0])
- One sub-module, sprite_anim_counter, contains the tick and frame counters with anim_en and the wrap logic. It is reusable for the tank and explosion sprites.
- The top level holds the shadow latch, the hit test and the address register.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles while frame_start=1 -> rom_address=0, sprite_hit=0, anim_frame=0. After release, the first frame_start latches the inputs.
- Basic hit: coin_x=100, coin_y=50, active=1, frame_start pulse, then scan DrawX=100, DrawY=50, blank=1 -> next cycle sprite_hit=1, rom_address=0. DrawX=115, DrawY=65 -> rom_address=255. DrawX=116 -> sprite_hit=0, rom_address=0.
- Animation: anim_en=1, issue 8 frame_start pulses -> anim_frame=1, and pixel (100,50) gives rom_address=256. After 32 pulses anim_frame wraps to 0. With anim_en=0, 10 pulses -> no change.
- Shadow latch: change coin_x to 200 mid-frame -> pixel (100,50) still hits. After the next frame_start, pixel (200,50) hits and (100,50) does not.
- Edge clip: coin_x=630, coin_y=470 -> (639,479) hits with rom_address=9*16+9=153. (0,0) never hits. blank=0 inside the box -> sprite_hit=0.
- Inactive: coin_active=0 latched -> sprite_hit=0 and rom_address=0 over a full 640x480 scan.

Source files
------------

// File: rtl/coin_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coin_sprite_pkg
// Brief    : Shared constants, types and helpers for the coin sprite path.
// Revision : 1.0 - initial release
// ============================================================================
package coin_sprite_pkg;

  // Default sprite geometry and animation timing
  localparam int c_SPR_W       = 16;
  localparam int c_SPR_H       = 16;
  localparam int c_NUM_FRAMES  = 4;
  localparam int c_FRAME_TICKS = 8;
  localparam int c_FRAME_SIZE  = c_SPR_W * c_SPR_H;

  // Visible screen area
  localparam int c_H_ACTIVE = 640;
  localparam int c_V_ACTIVE = 480;

  typedef logic [9:0] screen_coord_t;

  // Bit width needed to index n items, never less than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : coin_sprite_pkg
`default_nettype wire

// File: rtl/coin_sprite_addr_gen_anim_counter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_counter
// Brief    : Video-frame tick counter and animation frame index with wrap.
//            Shared by the coin, tank and explosion sprites.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_anim_counter
  import coin_sprite_pkg::*;
#(
  parameter int NUM_FRAMES  = c_NUM_FRAMES,
  parameter int FRAME_TICKS = c_FRAME_TICKS,
  localparam int FRAME_W    = width_of(NUM_FRAMES),
  localparam int TICK_W     = width_of(FRAME_TICKS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               advance,
  input  logic               en,
  output logic [FRAME_W-1:0] frame
);

  localparam logic [TICK_W-1:0]  c_TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0] c_FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  logic [TICK_W-1:0]  r_tick;
  logic [FRAME_W-1:0] r_frame;

  // Count video frames while enabled; step the animation frame on tick wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tick  <= '0;
      r_frame <= '0;
    end else if (advance && en) begin
      if (r_tick == c_TICK_LAST) begin
        r_tick  <= '0;
        r_frame <= (r_frame == c_FRAME_LAST) ? '0 : r_frame + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  assign frame = r_frame;

endmodule : sprite_anim_counter
`default_nettype wire

// File: rtl/coin_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : coin_sprite_addr_gen
// Brief    : Coin sprite hit test and ROM address generator. Latches the coin
//            position once per video frame and registers address/hit with a
//            single pixel-clock of latency.
// Revision : 1.0 - initial release
// ============================================================================
module coin_sprite_addr_gen
  import coin_sprite_pkg::*;
#(
  parameter int SPR_W       = c_SPR_W,
  parameter int SPR_H       = c_SPR_H,
  parameter int NUM_FRAMES  = c_NUM_FRAMES,
  parameter int FRAME_TICKS = c_FRAME_TICKS,
  parameter int ADDR_W      = 13,
  localparam int FRAME_W    = width_of(NUM_FRAMES)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [9:0]         coin_x,
  input  logic [9:0]         coin_y,
  input  logic               coin_active,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_address,
  output logic               sprite_hit,
  output logic [FRAME_W-1:0] anim_frame
);

  // Shift amounts replace the multiplies (dimensions are powers of two)
  localparam int c_XW = $clog2(SPR_W);
  localparam int c_YW = $clog2(SPR_H);

  screen_coord_t r_lx;
  screen_coord_t r_ly;
  logic          r_lact;

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic               w_in_x;
  logic               w_in_y;
  logic               w_inside;
  logic [ADDR_W-1:0]  w_addr;

  sprite_anim_counter #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_anim (
    .clk     (vga_clk),
    .reset_n (reset_n),
    .advance (frame_start),
    .en      (anim_en),
    .frame   (anim_frame)
  );

  // Shadow latch: coin position only changes at the frame boundary
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_lx   <= '0;
      r_ly   <= '0;
      r_lact <= 1'b0;
    end else if (frame_start) begin
      r_lx   <= coin_x;
      r_ly   <= coin_y;
      r_lact <= coin_active;
    end
  end

  // Offsets are signed so that pixels left/above the sprite never alias in
  assign w_dx = $signed({1'b0, DrawX}) - $signed({1'b0, r_lx});
  assign w_dy = $signed({1'b0, DrawY}) - $signed({1'b0, r_ly});

  assign w_in_x   = ~w_dx[10] & (w_dx[9:0] < 10'(SPR_W));
  assign w_in_y   = ~w_dy[10] & (w_dy[9:0] < 10'(SPR_H));
  assign w_inside = r_lact & blank & w_in_x & w_in_y;

  assign w_addr = (ADDR_W'(anim_frame) << (c_XW + c_YW))
                + (ADDR_W'(w_dy[c_YW-1:0]) << c_XW)
                +  ADDR_W'(w_dx[c_XW-1:0]);

  // Register the address and hit flag; outside the sprite the address parks at 0
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rom_address <= '0;
      sprite_hit  <= 1'b0;
    end else begin
      rom_address <= w_inside ? w_addr : '0;
      sprite_hit  <= w_inside;
    end
  end

endmodule : coin_sprite_addr_gen
`default_nettype wire
